// File: rtl/wisc_pkg.sv
// wisc_pkg: shared types and constants for the WISC front end.
// Fetch FSM states, NOP encoding and the halt opcode.
package wisc_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    WAIT_TGT = 2'd2,
    HALTED   = 2'd3
  } fetch_state_t;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [3:0]  OPC_HLT   = 4'hF;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with bubble, load and hold.
// Ports: clk, rst (async low), bubble/load/hold, instr/pc_plus1 in, q out.
module if_id_reg
  import wisc_pkg::*;
#(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   bubble,
  input  logic                   hold,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_plus1_in,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc_plus1,
  output logic                   valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr    <= INSTR_WIDTH'(NOP_INSTR);
      pc_plus1 <= '0;
      valid    <= 1'b0;
    end else if (bubble) begin
      instr    <= INSTR_WIDTH'(NOP_INSTR);
      pc_plus1 <= '0;
      valid    <= 1'b0;
    end else if (load && !hold) begin
      instr    <= instr_in;
      pc_plus1 <= pc_plus1_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: WISC fetch stage; PC register, fetch FSM, IF/ID register.
// Ports: clk, rst (async low), hazards, redirect, imem, IF_ID_*, PC_update,
// halted. Define FETCH_HALT_EN to stop fetch on an OPC_HLT instruction.
module fetch_unit
  import wisc_pkg::*;
#(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_hazard,
  input  logic                   PC_hazard,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] IF_ID_instr,
  output logic [PC_WIDTH-1:0]    IF_ID_pc_plus1,
  output logic                   IF_ID_valid,
  output logic                   PC_update,
  output logic                   halted
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic                pcu_d;
  logic                load, bubble, hold;
  logic                is_hlt;

  assign pc_inc    = pc_q + PC_ONE;
  assign imem_addr = pc_q;

`ifdef FETCH_HALT_EN
  assign is_hlt = (imem_data[INSTR_WIDTH-1 -: 4] == OPC_HLT);
  assign halted = (state_q == HALTED);
`else
  assign is_hlt = 1'b0;
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      PC_update <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      PC_update <= pcu_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pcu_d   = 1'b0;
    load    = 1'b0;
    bubble  = 1'b0;
    hold    = 1'b0;
    if (state_q == HALTED) begin
      bubble = 1'b1;
    end else if (redirect_valid) begin
      pc_d    = redirect_target;
      bubble  = 1'b1;
      pcu_d   = 1'b1;
      state_d = RUN;
    end else if (PC_hazard || state_q == WAIT_TGT) begin
      bubble  = 1'b1;
      state_d = WAIT_TGT;
    end else if (data_hazard) begin
      hold    = 1'b1;
      state_d = STALL;
    end else begin
      load = 1'b1;
      // A halt instruction is latched but the PC stays on it.
      if (is_hlt) begin
        state_d = HALTED;
      end else begin
        pc_d    = pc_inc;
        state_d = RUN;
      end
    end
  end

  if_id_reg #(
    .PC_WIDTH   (PC_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bubble     (bubble),
    .hold       (hold),
    .instr_in   (imem_data),
    .pc_plus1_in(pc_inc),
    .instr      (IF_ID_instr),
    .pc_plus1   (IF_ID_pc_plus1),
    .valid      (IF_ID_valid)
  );

endmodule
